// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with an internal round-robin / fixed-priority arbiter and a registered output.
// Optional feature: define ARB_MUX_LOCK_EN to add in_lock, which holds the grant on one channel across several words.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_lock,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic [SEL_W-1:0]    r_rr_ptr;
`ifdef ARB_MUX_LOCK_EN
  logic                r_locked;
  logic [SEL_W-1:0]    r_lock_chan;
`endif

  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_gidx;
  logic                w_found;
  logic [SEL_W:0]      w_sum;
  logic [SEL_W-1:0]    w_idx;
  logic                w_space;
  logic                w_xfer;
  logic [SEL_W-1:0]    w_rr_next;
  logic [WIDTH-1:0]    w_chan_data [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slice
    assign w_chan_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Arbiter: pick a single channel index, then expand it to a one-hot grant.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    if (mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_found && in_valid[i]) begin
          w_found = 1'b1;
          w_gidx  = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
        if (w_sum >= (SEL_W+1)'(CHANNELS)) begin
          w_sum = w_sum - (SEL_W+1)'(CHANNELS);
        end
        w_idx = w_sum[SEL_W-1:0];
        if (!w_found && in_valid[w_idx]) begin
          w_found = 1'b1;
          w_gidx  = w_idx;
        end
      end
    end
`ifdef ARB_MUX_LOCK_EN
    // A locked channel keeps the grant even while its in_valid is low.
    if (r_locked) begin
      w_found = 1'b1;
      w_gidx  = r_lock_chan;
    end
`endif
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_space   = ~r_out_valid | out_ready;
  assign in_ready  = w_grant & {CHANNELS{w_space & rst_n}};
  assign w_xfer    = |(in_valid & in_ready);
  assign w_rr_next = (w_gidx == SEL_W'(CHANNELS-1)) ? '0 : w_gidx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
`ifdef ARB_MUX_LOCK_EN
      r_locked    <= 1'b0;
      r_lock_chan <= '0;
`endif
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_chan_data[w_gidx];
        r_out_chan  <= w_gidx;
        if (!mode) begin
          r_rr_ptr <= w_rr_next;
        end
`ifdef ARB_MUX_LOCK_EN
        if (in_lock[w_gidx]) begin
          r_locked    <= 1'b1;
          r_lock_chan <= w_gidx;
        end else begin
          r_locked    <= 1'b0;
        end
`endif
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios followed by random traffic, all checked against a queue-free scan model.
module tb_arb_mux;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic [N-1:0]   lk_cur;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_lock(lk_cur),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_chan(out_chan)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        m_valid;
  logic [31:0] m_data;
  int          m_chan;
  int          m_rr;
  bit          m_locked;
  int          m_lock_chan;
  logic [31:0] d [N];
  logic [31:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic md, input logic [N-1:0] v);
    if (m_locked) return m_lock_chan;
    for (int k = 0; k < N; k++) begin
      int c = md ? k : (m_rr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_rr = 0;
    m_locked = 1'b0; m_lock_chan = 0;
  endtask

  task automatic do_reset();
    in_valid = '1;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_chan", 64'(out_chan), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic md, input logic [N-1:0] v, input logic ordy,
                      input logic [N-1:0] lk, input int xchan);
    int g;
    bit space;
    bit xfer;
    logic [N-1:0] er;
    mode = md; in_valid = v; out_ready = ordy; lk_cur = lk;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
    #1;
    space = !m_valid || ordy;
    g = pick(md, v);
    er = (space && g >= 0) ? (N'(1) << g) : '0;
    check("in_ready", 64'(in_ready), 64'(er));
    xfer = space && (g >= 0) && v[g];
    @(posedge clk);
    if (xfer) begin
      m_data = d[g]; m_chan = g; m_valid = 1'b1;
      if (!md) m_rr = (g + 1) % N;
      if (lk[g]) begin m_locked = 1'b1; m_lock_chan = g; end
      else m_locked = 1'b0;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_chan", 64'(out_chan), 64'(m_chan));
    if (xchan >= 0) begin
      check("seq_chan", 64'(out_chan), 64'(xchan));
      check("seq_valid", 64'(out_valid), 64'(1));
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) d[i] = $urandom;
  endtask

  initial begin
    rst_n = 1'b1; mode = 1'b0; in_valid = '0; out_ready = 1'b0;
    in_data = '0; lk_cur = '0;
    for (int i = 0; i < N; i++) d[i] = '0;
    model_reset();
    #1;
    do_reset();

    // single transfer from ch2
    rand_data();
    d[2] = 32'hDEAD_BEEF;
    step(1'b0, 4'b0100, 1'b1, 4'b0000, 2);
    check("single_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);

    // reset with a word held in the output register
    do_reset();

    // round-robin fairness with all channels requesting
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step(1'b0, 4'b1111, 1'b1, 4'b0000, i % N);
    end

    // fixed priority
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step(1'b1, 4'b1010, 1'b1, 4'b0000, 1);
    end

    // backpressure
    rand_data();
    step(1'b0, 4'b0001, 1'b1, 4'b0000, 0);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step(1'b0, 4'b0001, 1'b0, 4'b0000, -1);
      check("bp_stable", 64'(out_data), 64'(held));
    end
    rand_data();
    step(1'b0, 4'b0001, 1'b1, 4'b0000, 0);
    check("bp_new_data", 64'(out_data), 64'(d[0]));

    // wrap and skip, then fixed mode leaves the pointer alone
    do_reset();
    rand_data();
    step(1'b0, 4'b0100, 1'b1, 4'b0000, 2);
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 0);
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 2);
    step(1'b1, 4'b0101, 1'b1, 4'b0000, 0);
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, -1);
    check("drained", 64'(out_valid), 64'(0));

`ifdef ARB_MUX_LOCK_EN
    // lock: ch1 holds the grant for three words
    do_reset();
    rand_data();
    step(1'b0, 4'b0001, 1'b1, 4'b0000, 0);
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1);
    rand_data();
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1);
    rand_data();
    step(1'b0, 4'b1111, 1'b1, 4'b0000, 1);
    rand_data();
    step(1'b0, 4'b1111, 1'b1, 4'b0000, 2);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] lk;
      rand_data();
`ifdef ARB_MUX_LOCK_EN
      lk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`else
      lk = '0;
`endif
      step(1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 3) != 0), lk, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
